// File: rtl/gpio_link_pkg.sv
// Shared definitions for the GPIO nibble link: handshake polarities, nibble width and the
// transmit-scheduler state encoding.
package gpio_link_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // Also used by the nibble buffer on the far side of the pins.
    localparam logic READY_ACTIVE = 1'b0;
    localparam logic VALID_ACTIVE = 1'b1;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StGrant     = 3'd1,
        StHiWaitAck = 3'd2,
        StHiWaitRel = 3'd3,
        StLoWaitAck = 3'd4,
        StLoWaitRel = 3'd5
    } link_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1 (mod NREQ).
// The priority pointer itself lives in the parent.
module rr_arbiter
    import gpio_link_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned      cand;
    logic [IDW-1:0]   cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand     = (32'(ptr_i) + i) % NREQ;
            cand_idx = IDW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/gpio_nibble_tx_scheduler.sv
// Shares the 4-bit GPIO nibble link among NREQ byte requesters: round-robin grant, then two
// four-phase valid/ready handshakes (high nibble first), each wait bounded by a timeout.
module gpio_nibble_tx_scheduler
    import gpio_link_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned TMO_W = 8,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [NIBBLE_W-1:0] link_data,
    output logic                link_valid,
    input  logic                link_ready_n,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic                timeout_err
);

    // Abort fires on the edge where the timer would reach its terminal count.
    localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [1:0]          sync_q;
    logic                rdy_n_s;
    link_state_e         state_q;
    logic [7:0]          byte_q;
    logic [IDW-1:0]      ptr_q;
    logic [TMO_W-1:0]    tmr_q;
    logic [NREQ-1:0]     req_ready_q;
    logic [NIBBLE_W-1:0] link_data_q;
    logic                link_valid_q;
    logic [IDW-1:0]      grant_id_q;
    logic                busy_q;
    logic                tmo_err_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDW-1:0]      arb_idx;
    logic                arb_any;
    logic [7:0]          sel_byte;
    logic                wait_st;
    logic                wait_done;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign rdy_n_s = sync_q[1];

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) sel_byte = req_data[8*i +: 8];
        end
    end

    always_comb begin
        wait_st   = 1'b0;
        wait_done = 1'b0;
        case (state_q)
            StHiWaitAck, StLoWaitAck: begin
                wait_st   = 1'b1;
                wait_done = (rdy_n_s == READY_ACTIVE);
            end
            StHiWaitRel, StLoWaitRel: begin
                wait_st   = 1'b1;
                wait_done = (rdy_n_s != READY_ACTIVE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], link_ready_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_q       <= '0;
            ptr_q        <= IDW'(NREQ - 1);
            tmr_q        <= '0;
            req_ready_q  <= '0;
            link_data_q  <= '0;
            link_valid_q <= ~VALID_ACTIVE;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            req_ready_q <= '0;
            tmo_err_q   <= 1'b0;
            if (wait_st && !wait_done) begin
                if (tmr_q == TmoLast) begin
                    // Dead chip: drop the byte, keep ptr so this requester loses priority.
                    link_valid_q <= ~VALID_ACTIVE;
                    link_data_q  <= '0;
                    busy_q       <= 1'b0;
                    tmo_err_q    <= 1'b1;
                    tmr_q        <= '0;
                    state_q      <= StIdle;
                end else begin
                    tmr_q <= tmr_q + 1'b1;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (arb_any && rdy_n_s != READY_ACTIVE) begin
                            byte_q      <= sel_byte;
                            req_ready_q <= arb_gnt;
                            grant_id_q  <= arb_idx;
                            ptr_q       <= arb_idx;
                            busy_q      <= 1'b1;
                            state_q     <= StGrant;
                        end
                    end
                    StGrant: begin
                        link_data_q  <= byte_q[7:4];
                        link_valid_q <= VALID_ACTIVE;
                        tmr_q        <= '0;
                        state_q      <= StHiWaitAck;
                    end
                    StHiWaitAck: begin
                        link_valid_q <= ~VALID_ACTIVE;
                        tmr_q        <= '0;
                        state_q      <= StHiWaitRel;
                    end
                    StHiWaitRel: begin
                        link_data_q  <= byte_q[3:0];
                        link_valid_q <= VALID_ACTIVE;
                        tmr_q        <= '0;
                        state_q      <= StLoWaitAck;
                    end
                    StLoWaitAck: begin
                        link_valid_q <= ~VALID_ACTIVE;
                        tmr_q        <= '0;
                        state_q      <= StLoWaitRel;
                    end
                    StLoWaitRel: begin
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= StIdle;
                    end
                    default: begin
                        link_valid_q <= ~VALID_ACTIVE;
                        busy_q       <= 1'b0;
                        tmr_q        <= '0;
                        state_q      <= StIdle;
                    end
                endcase
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign link_data   = link_data_q;
    assign link_valid  = link_valid_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_gpio_nibble_tx_scheduler.sv
// Directed bench for gpio_nibble_tx_scheduler: behavioural chip responder, table of arbitration
// vectors, hand-written timeout/reset/stuck-ready sequences and a random-delay byte scoreboard.
module tb_gpio_nibble_tx_scheduler;

    localparam int NREQ  = 2;
    localparam int TMO_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [3:0]  link_data;
    logic        link_valid;
    logic        link_ready_n = 1'b1;
    logic [0:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    gpio_nibble_tx_scheduler #(
        .NREQ  (NREQ),
        .TMO_W (TMO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .link_data    (link_data),
        .link_valid   (link_valid),
        .link_ready_n (link_ready_n),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Chip responder: acks a valid nibble after a delay, releases after another delay.
    bit chip_auto = 1'b0;
    bit chip_rand = 1'b0;
    int ack_fix = 3;
    int rel_fix = 2;
    int cst = 0;
    int ccnt = 0;

    always @(negedge clk) begin
        if (rst || !chip_auto) begin
            cst = 0;
            if (chip_auto) link_ready_n = 1'b1;
        end else begin
            case (cst)
                0: if (link_valid) begin
                    ccnt = chip_rand ? int'($urandom_range(0, 10)) : ack_fix;
                    if (ccnt == 0) begin link_ready_n = 1'b0; cst = 2; end
                    else cst = 1;
                end
                1: begin
                    ccnt--;
                    if (ccnt == 0) begin link_ready_n = 1'b0; cst = 2; end
                end
                2: if (!link_valid) begin
                    ccnt = chip_rand ? int'($urandom_range(0, 10)) : rel_fix;
                    if (ccnt == 0) begin link_ready_n = 1'b1; cst = 0; end
                    else cst = 3;
                end
                default: begin
                    ccnt--;
                    if (ccnt == 0) begin link_ready_n = 1'b1; cst = 0; end
                end
            endcase
        end
    end

    // Link monitor: data must hold while valid is high; count timeout pulses.
    int         viol = 0;
    int         tmo_pulses = 0;
    logic       mon_pv = 1'b0;
    logic [3:0] mon_pd = '0;

    always @(negedge clk) begin
        if (mon_pv && link_valid && link_data !== mon_pd) viol++;
        if (timeout_err) tmo_pulses++;
        mon_pv = link_valid;
        mon_pd = link_data;
    end

    task automatic wait_rr(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (req_ready != 0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Rebuild the byte from the first two valid rising edges until busy drops.
    task automatic capture(output logic [7:0] b, output int nn, output int first);
        logic       pv;
        logic [3:0] n0, n1;
        pv = 1'b0; n0 = '0; n1 = '0; nn = 0; first = -1; b = '0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) return;
            if (link_valid && !pv) begin
                if (nn == 0) n0 = link_data;
                else if (nn == 1) n1 = link_data;
                if (first < 0) first = c;
                nn++;
            end
            pv = link_valid;
            b  = {n0, n1};
            @(negedge clk);
        end
    endtask

    task automatic xfer(input string nm, input int exp_gid, input logic [7:0] exp_byte,
                        input logic [1:0] nxt_valid, input logic [15:0] nxt_data);
        bit         ok;
        logic [7:0] b;
        int         nn, first;
        wait_rr(ok);
        check({nm, " grant_seen"}, 32'(ok), 32'd1);
        if (!ok) return;
        check({nm, " req_ready"}, 32'(req_ready), 32'(2'b01 << exp_gid));
        check({nm, " grant_id"}, 32'(grant_id), 32'(exp_gid));
        req_valid = nxt_valid;
        req_data  = nxt_data;
        capture(b, nn, first);
        check({nm, " byte"}, 32'(b), 32'(exp_byte));
        check({nm, " busy_done"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] data;
        int          gid;
        logic [7:0]  byt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        bit         ok;
        logic [7:0] b;
        int         nn, first, cnt, bad, t0;

        vecs[0] = '{2'b11, 16'h3412, 0, 8'h12};
        vecs[1] = '{2'b11, 16'h3412, 1, 8'h34};
        vecs[2] = '{2'b11, 16'h3412, 0, 8'h12};
        vecs[3] = '{2'b11, 16'h3412, 1, 8'h34};
        vecs[4] = '{2'b10, 16'h5600, 1, 8'h56};
        vecs[5] = '{2'b01, 16'h0077, 0, 8'h77};
        vecs[6] = '{2'b11, 16'h9988, 1, 8'h99};
        vecs[7] = '{2'b01, 16'h00AB, 0, 8'hAB};

        // Reset state and single-requester latency
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({req_ready, link_data, link_valid, grant_id, busy, timeout_err}),
              32'd0);
        rst = 1'b0;
        chip_auto = 1'b1;
        t0 = tmo_pulses;
        @(negedge clk);
        req_valid = 2'b01;
        req_data  = 16'h00A5;
        @(negedge clk);
        check("t1 req_ready latency", 32'(req_ready), 32'h1);
        check("t1 busy at grant", 32'(busy), 32'd1);
        req_valid = '0;
        capture(b, nn, first);
        check("t1 valid latency", 32'(first), 32'd1);
        check("t1 nibble count", 32'(nn), 32'd2);
        check("t1 byte", 32'(b), 32'hA5);
        check("t1 busy done", 32'(busy), 32'd0);
        check("t1 no timeout", 32'(tmo_pulses - t0), 32'd0);

        // Round-robin table from a fresh reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_valid = vecs[0].valid;
        req_data  = vecs[0].data;
        for (int k = 0; k < 8; k++) begin
            xfer($sformatf("rr[%0d]", k), vecs[k].gid, vecs[k].byt,
                 (k < 7) ? vecs[k+1].valid : 2'b00, (k < 7) ? vecs[k+1].data : 16'h0);
        end

        // Chip never acks: abort after 15 cycles in HI_WAIT_ACK
        chip_auto = 1'b0;
        link_ready_n = 1'b1;
        req_valid = 2'b10;
        req_data  = 16'hC300;
        wait_rr(ok);
        check("t3 grant seen", 32'(ok), 32'd1);
        check("t3 grant_id", 32'(grant_id), 32'd1);
        req_valid = '0;
        for (int c = 0; c < 10 && !link_valid; c++) @(negedge clk);
        check("t3 valid raised", 32'(link_valid), 32'd1);
        check("t3 hi nibble", 32'(link_data), 32'hC);
        cnt = 0;
        for (int c = 0; c < 40 && !timeout_err; c++) begin
            @(negedge clk);
            cnt++;
        end
        check("t3 timeout cycles", 32'(cnt), 32'd15);
        check("t3 abort outputs", 32'({link_valid, link_data, busy}), 32'd0);
        @(negedge clk);
        check("t3 timeout one pulse", 32'(timeout_err), 32'd0);
        chip_auto = 1'b1;
        req_valid = 2'b01;
        req_data  = 16'h003C;
        xfer("t3 after", 0, 8'h3C, 2'b00, 16'h0);

        // Chip busy (ready_n low) across reset release: no grant until it idles
        chip_auto = 1'b0;
        link_ready_n = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = 2'b01;
        req_data  = 16'h0096;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 0 || busy) bad++;
        end
        check("t4 no grant while chip busy", 32'(bad), 32'd0);
        link_ready_n = 1'b1;
        chip_auto = 1'b1;
        xfer("t4 after", 0, 8'h96, 2'b00, 16'h0);

        // Reset during LO_WAIT_ACK
        ack_fix = 8;
        req_valid = 2'b10;
        req_data  = 16'hE100;
        wait_rr(ok);
        check("t5 grant_id", 32'(grant_id), 32'd1);
        req_valid = '0;
        cnt = 0;
        begin
            logic pv;
            pv = link_valid;
            for (int c = 0; c < 100 && cnt < 2; c++) begin
                @(negedge clk);
                if (link_valid && !pv) cnt++;
                pv = link_valid;
            end
        end
        check("t5 reached low nibble", 32'(cnt), 32'd2);
        check("t5 low nibble", 32'(link_data), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t5 outputs after reset",
              32'({req_ready, link_data, link_valid, grant_id, busy, timeout_err}), 32'd0);
        rst = 1'b0;
        ack_fix = 3;
        req_valid = 2'b11;
        req_data  = 16'h2211;
        xfer("t5 after", 0, 8'h11, 2'b00, 16'h0);

        // Random handshake delays, 200 bytes
        chip_rand = 1'b1;
        t0 = tmo_pulses;
        for (int i = 0; i < 200; i++) begin
            int         r;
            logic [7:0] bv;
            r  = int'($urandom_range(0, 1));
            bv = 8'($urandom_range(0, 255));
            req_valid = '0;
            req_valid[r] = 1'b1;
            req_data = (r == 1) ? {bv, 8'($urandom_range(0, 255))} : {8'($urandom_range(0, 255)), bv};
            xfer($sformatf("rand[%0d]", i), r, bv, 2'b00, 16'h0);
        end
        check("t6 no timeouts", 32'(tmo_pulses - t0), 32'd0);
        check("data stable while valid", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_nibble_tx_scheduler.md
Name: gpio_nibble_tx_scheduler

Overview:
Sequences and shares the 4-bit GPIO nibble link (data[3:0] plus valid strobe, active-low ready from the chip) among NREQ on-chip byte requesters.
- Round-robin arbitration between requesters.
- Each granted byte is split into two nibbles, high nibble first.
- Each nibble goes out with a four-phase valid/ready handshake against the external chip.
- Every wait is bounded by a timeout so a dead chip cannot hang the link.
- Sits between internal producers and the GPIO pins feeding the nibble buffer.

Parameters:
NREQ, 2, number of requesters (2..8)
TMO_W, 8, timeout counter width; a wait aborts after 2^TMO_W-1 cycles

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  requester i has a byte pending; held until accepted
req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i]
req_ready  out  NREQ  one-cycle pulse: byte of requester i latched
link_data  out  4  nibble to GPIO
link_valid  out  1  nibble valid strobe to GPIO, active high
link_ready_n  in  1  chip handshake, asynchronous, 0 = nibble taken, 1 = idle
grant_id  out  $clog2(NREQ) (min 1)  requester currently being served
busy  out  1  high from grant until byte done or aborted
timeout_err  out  1  one-cycle pulse on handshake abort

Behaviour:
- Reset: all outputs 0; FSM = IDLE; rr pointer = NREQ-1, so requester 0 wins first; synchronizer flops = 1; timeout counter = 0.
- link_ready_n passes through a 2-flop synchronizer; FSM uses only the synchronized value (rdy_n_s).
- FSM states: IDLE, GRANT, HI_WAIT_ACK, HI_WAIT_REL, LO_WAIT_ACK, LO_WAIT_REL.
- IDLE:
  - If any req_valid is set and rdy_n_s==1, pick the first set bit searching from ptr+1 modulo NREQ.
  - Latch that requester's byte, pulse its req_ready, set grant_id, ptr and busy, go to GRANT.
  - If rdy_n_s==0 (chip not idle), stay in IDLE.
- GRANT: drive link_data = byte[7:4], set link_valid=1, clear timer, go to HI_WAIT_ACK.
- HI_WAIT_ACK: when rdy_n_s==0, set link_valid=0 and go to HI_WAIT_REL. link_data holds throughout.
- HI_WAIT_REL: when rdy_n_s==1, drive link_data = byte[3:0], set link_valid=1, go to LO_WAIT_ACK.
- LO_WAIT_ACK: when rdy_n_s==0, set link_valid=0 and go to LO_WAIT_REL.
- LO_WAIT_REL: when rdy_n_s==1, clear busy and go to IDLE. The next grant is possible in that same IDLE cycle.
- Timer:
  - Increments every cycle in any WAIT state and clears on each transition.
  - At terminal count (2^TMO_W-1): link_valid=0, link_data=0, busy=0, pulse timeout_err, go to IDLE.
  - ptr is kept, so the aborted requester loses priority; its byte is dropped, not retried.
- Latency: req_valid rising in IDLE at cycle N gives req_ready at N+1 and link_valid=1 with the high nibble at N+2.
- Arbitration fairness: req_valid is sampled only in IDLE. A requester that deasserts before grant is simply skipped. Simultaneous requests are served in rotating order.
- Sync-domain rule: link_data changes only while link_valid==0, or in the same cycle link_valid rises; never while valid is high.
- Reset mid-transfer: immediate return to reset values; no partial nibble completion.
- Any illegal state decodes to IDLE with link_valid=0.

Decomposition:
- Package gpio_link_pkg holds:
  - the FSM state enum (3-bit encoding);
  - NIBBLE_W=4;
  - localparams READY_ACTIVE=1'b0 and VALID_ACTIVE=1'b1, shared with the nibble buffer.
- Sub-module rr_arbiter (NREQ-wide): inputs req and ptr, output one-hot grant plus index. Purely combinational; ptr is held in the parent.

Test Plan:
1. Single requester 0, byte 0xA5; chip acks each valid after 3 cycles and releases 2 cycles later -> req_ready[0] 1 cycle after req_valid; link_data 0xA then 0x5; busy drops after second release; timeout_err never pulses.
2. Both requesters valid continuously, bytes 0x12 and 0x34 -> bytes served in order 0x12, 0x34, 0x12, ...; grant_id alternates 0,1,0.
3. Chip never acks (link_ready_n stuck 1) with TMO_W=4 -> timeout_err pulses 15 cycles after entering HI_WAIT_ACK; link_valid returns to 0; next request is served normally.
4. link_ready_n stuck 0 at reset release with req_valid high -> no grant and req_ready stays 0 until link_ready_n returns to 1; then transfer starts.
5. Assert rst during LO_WAIT_ACK -> next cycle all outputs are 0 and FSM is in IDLE; next grant goes to requester 0.
6. Random ack/release delays of 0–10 cycles with 200 random bytes -> a scoreboard rebuilds each byte from nibble pairs; all match, and link_data never changes while link_valid is high.
